// File: rtl/lcd_zone_display.sv
// HD44780 8-bit write-only driver: zone free-space counts on line 1, elapsed time on line 2.
// Frames are drawn from a snapshot of the inputs and only when the inputs have changed.
module lcd_zone_display #(
    parameter int ZONES    = 2,
    parameter int CAR_W    = 4,
    parameter int TIME_W   = 6,
    parameter int TICK_DIV = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     power,
    input  logic [ZONES*CAR_W-1:0]   car,
    input  logic [TIME_W-1:0]        time_cnt,
    output logic                     RW,
    output logic                     EN,
    output logic                     RS,
    output logic [7:0]               data_bus,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int TCW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int NBYTES = 4*ZONES + 6;

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_IDLE  = 2'd2;
    localparam logic [1:0] S_FRAME = 2'd3;

    localparam logic [1:0] P_SETUP = 2'd0;
    localparam logic [1:0] P_PULSE = 2'd1;
    localparam logic [1:0] P_HOLD  = 2'd2;

    localparam logic [4:0] INIT_LAST  = 5'd3;
    localparam logic [4:0] FRAME_LAST = 5'(NBYTES-1);

    logic [TCW-1:0]          r_tick_cnt;
    logic                    w_tick;
    logic [1:0]              r_state, w_state_next;
    logic [1:0]              r_phase, w_phase_next;
    logic [4:0]              r_idx, w_idx_next;
    logic                    r_en, w_en_next;
    logic                    r_rs, w_rs_next;
    logic [7:0]              r_data, w_data_next;
    logic                    r_done, w_done_next;
    logic                    r_dirty;
    logic                    w_latch, w_set_dirty, w_mismatch, w_last;
    logic [ZONES*CAR_W-1:0]  r_snap_car;
    logic [TIME_W-1:0]       r_snap_time;
    logic [15:0]             w_zone_ascii [ZONES];
    logic [15:0]             w_time_ascii;
    logic                    w_cand_init, w_cand_rs;
    logic [4:0]              w_cand_idx, w_zk, w_tk;
    logic [7:0]              w_cand_byte;

    // Two ASCII digits {tens, units}; anything above 99 saturates to "99".
    function automatic logic [15:0] to_ascii(input logic [7:0] v);
        logic [7:0] t;
        logic [7:0] u;
        if (v > 8'd99) begin
            t = 8'd9;
            u = 8'd9;
        end else begin
            t = v / 8'd10;
            u = v % 8'd10;
        end
        return {8'h30 + t, 8'h30 + u};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < ZONES; gi++) begin : g_zone
            assign w_zone_ascii[gi] = to_ascii({{(8-CAR_W){1'b0}}, r_snap_car[gi*CAR_W +: CAR_W]});
        end
    endgenerate
    assign w_time_ascii = to_ascii({{(8-TIME_W){1'b0}}, r_snap_time});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (!power || r_tick_cnt == TCW'(TICK_DIV-1)) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TCW'(1);
        end
    end
    assign w_tick = power && (r_tick_cnt == TCW'(TICK_DIV-1));

    // Candidate byte to load on the next SETUP: depends only on registered state.
    always_comb begin
        w_cand_init = (r_state == S_OFF) || (r_state == S_INIT);
        w_cand_idx  = (r_state == S_INIT || r_state == S_FRAME) ? r_idx + 5'd1 : 5'd0;
        w_zk        = w_cand_idx - 5'd1;
        w_tk        = w_cand_idx - 5'(4*ZONES+2);
        w_cand_rs   = 1'b0;
        w_cand_byte = 8'h00;
        if (w_cand_init) begin
            case (w_cand_idx)
                5'd0:    w_cand_byte = 8'h38;
                5'd1:    w_cand_byte = 8'h0C;
                5'd2:    w_cand_byte = 8'h06;
                default: w_cand_byte = 8'h01;
            endcase
        end else if (w_cand_idx == 5'd0) begin
            w_cand_byte = 8'h80;
        end else if (w_cand_idx <= 5'(4*ZONES)) begin
            w_cand_rs = 1'b1;
            for (int z = 0; z < ZONES; z++) begin
                if (w_zk[4:2] == 3'(z)) begin
                    case (w_zk[1:0])
                        2'd0:    w_cand_byte = 8'h41 + 8'(z);
                        2'd1:    w_cand_byte = w_zone_ascii[z][15:8];
                        2'd2:    w_cand_byte = w_zone_ascii[z][7:0];
                        default: w_cand_byte = 8'h20;
                    endcase
                end
            end
        end else if (w_cand_idx == 5'(4*ZONES+1)) begin
            w_cand_byte = 8'hC0;
        end else begin
            w_cand_rs = 1'b1;
            case (w_tk)
                5'd0:    w_cand_byte = 8'h54;
                5'd1:    w_cand_byte = 8'h3A;
                5'd2:    w_cand_byte = w_time_ascii[15:8];
                default: w_cand_byte = w_time_ascii[7:0];
            endcase
        end
    end

    assign w_last = (r_idx == ((r_state == S_INIT) ? INIT_LAST : FRAME_LAST));

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_idx_next   = r_idx;
        w_en_next    = r_en;
        w_rs_next    = r_rs;
        w_data_next  = r_data;
        w_done_next  = 1'b0;
        w_latch      = 1'b0;
        w_set_dirty  = 1'b0;
        if (!power) begin
            w_state_next = S_OFF;
            w_phase_next = P_SETUP;
            w_idx_next   = 5'd0;
            w_en_next    = 1'b0;
            w_rs_next    = 1'b0;
            w_data_next  = 8'h00;
        end else if (w_tick) begin
            case (r_state)
                S_OFF: begin
                    w_state_next = S_INIT;
                    w_phase_next = P_SETUP;
                    w_idx_next   = w_cand_idx;
                    w_en_next    = 1'b0;
                    w_rs_next    = w_cand_rs;
                    w_data_next  = w_cand_byte;
                end
                S_IDLE: begin
                    if (r_dirty) begin
                        w_state_next = S_FRAME;
                        w_latch      = 1'b1;
                        w_phase_next = P_SETUP;
                        w_idx_next   = w_cand_idx;
                        w_en_next    = 1'b0;
                        w_rs_next    = w_cand_rs;
                        w_data_next  = w_cand_byte;
                    end
                end
                default: begin
                    case (r_phase)
                        P_SETUP: begin
                            w_phase_next = P_PULSE;
                            w_en_next    = 1'b1;
                        end
                        P_PULSE: begin
                            w_phase_next = P_HOLD;
                            w_en_next    = 1'b0;
                        end
                        default: begin
                            if (w_last) begin
                                w_state_next = S_IDLE;
                                w_set_dirty  = (r_state == S_INIT);
                                w_done_next  = (r_state == S_FRAME);
                            end else begin
                                w_phase_next = P_SETUP;
                                w_idx_next   = w_cand_idx;
                                w_en_next    = 1'b0;
                                w_rs_next    = w_cand_rs;
                                w_data_next  = w_cand_byte;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_OFF;
            r_phase <= P_SETUP;
            r_idx   <= 5'd0;
            r_en    <= 1'b0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_idx   <= w_idx_next;
            r_en    <= w_en_next;
            r_rs    <= w_rs_next;
            r_data  <= w_data_next;
            r_done  <= w_done_next;
        end
    end

    // Latching the snapshot wins over a same-cycle mismatch against the old snapshot.
    assign w_mismatch = (car != r_snap_car) || (time_cnt != r_snap_time);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap_car  <= '0;
            r_snap_time <= '0;
            r_dirty     <= 1'b1;
        end else if (w_latch) begin
            r_snap_car  <= car;
            r_snap_time <= time_cnt;
            r_dirty     <= 1'b0;
        end else if (w_mismatch || w_set_dirty) begin
            r_dirty     <= 1'b1;
        end
    end

    assign RW         = 1'b0;
    assign EN         = r_en;
    assign RS         = r_rs;
    assign data_bus   = r_data;
    assign busy       = (r_state == S_INIT) || (r_state == S_FRAME);
    assign frame_done = r_done;
endmodule

// File: tb/tb_lcd_zone_display.sv
// Directed bench for lcd_zone_display: captures every EN-strobed byte and compares frames
// against hand-computed vectors, plus sequences for mid-frame change, power drop and reset.
module tb_lcd_zone_display;
    logic       clk = 1'b0;
    logic       rst;
    logic       power;
    logic [7:0] car;
    logic [6:0] time_cnt;
    logic       RW, EN, RS, busy, frame_done;
    logic [7:0] data_bus;

    int checks = 0;
    int errors = 0;
    logic [8:0] cap_q[$];
    int frames_done = 0;
    int en_hi = 0;
    logic en_prev = 1'b0;
    logic chk_width = 1'b1;

    typedef struct {
        logic [7:0] car;
        logic [6:0] tcnt;
        logic [7:0] z0t, z0u, z1t, z1u, tt, tu;
    } vec_t;

    lcd_zone_display #(.ZONES(2), .CAR_W(4), .TIME_W(7), .TICK_DIV(2)) dut (
        .clk(clk), .rst(rst), .power(power), .car(car), .time_cnt(time_cnt),
        .RW(RW), .EN(EN), .RS(RS), .data_bus(data_bus), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (EN && !en_prev) cap_q.push_back({RS, data_bus});
        if (EN) begin
            en_hi++;
        end else begin
            if (en_hi > 0 && chk_width) begin
                chk("en_width_clk", en_hi, 2);
                chk("hold_stable", {RS, data_bus}, cap_q[$]);
            end
            en_hi = 0;
        end
        if (frame_done) frames_done++;
        en_prev = EN;
    end

    task automatic wait_frames(input int n, input int budget, input string name);
        int cnt = 0;
        while (frames_done < n && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        chk(name, frames_done >= n, 1);
    endtask

    task automatic wait_size(input int n, input int budget, input string name);
        int cnt = 0;
        while (cap_q.size() < n && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        chk(name, cap_q.size() >= n, 1);
    endtask

    task automatic chk_pos(input string name, input int pos, input logic [8:0] exp);
        if (pos < cap_q.size()) begin
            chk(name, cap_q[pos], exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s actual=missing(pos %0d) required=%0h", name, pos, exp);
        end
    endtask

    task automatic check_frame(input int base, input vec_t v, input string name);
        logic [8:0] exp [14];
        exp = '{{1'b0, 8'h80}, {1'b1, 8'h41}, {1'b1, v.z0t}, {1'b1, v.z0u}, {1'b1, 8'h20},
                {1'b1, 8'h42}, {1'b1, v.z1t}, {1'b1, v.z1u}, {1'b1, 8'h20},
                {1'b0, 8'hC0}, {1'b1, 8'h54}, {1'b1, 8'h3A}, {1'b1, v.tt}, {1'b1, v.tu}};
        for (int i = 0; i < 14; i++) chk_pos($sformatf("%s_b%0d", name, i), base + i, exp[i]);
    endtask

    task automatic check_init(input int base, input string name);
        chk_pos({name, "_38"}, base + 0, 9'h038);
        chk_pos({name, "_0C"}, base + 1, 9'h00C);
        chk_pos({name, "_06"}, base + 2, 9'h006);
        chk_pos({name, "_01"}, base + 3, 9'h001);
    endtask

    initial begin
        vec_t vecs [6];
        vec_t v;
        int base;
        int fd;
        vecs[0] = '{8'h3C, 7'd7,   8'h31, 8'h32, 8'h30, 8'h33, 8'h30, 8'h37};
        vecs[1] = '{8'h3C, 7'd45,  8'h31, 8'h32, 8'h30, 8'h33, 8'h34, 8'h35};
        vecs[2] = '{8'h3C, 7'd63,  8'h31, 8'h32, 8'h30, 8'h33, 8'h36, 8'h33};
        vecs[3] = '{8'h3C, 7'd120, 8'h31, 8'h32, 8'h30, 8'h33, 8'h39, 8'h39};
        vecs[4] = '{8'hF0, 7'd99,  8'h30, 8'h30, 8'h31, 8'h35, 8'h39, 8'h39};
        vecs[5] = '{8'h9A, 7'd100, 8'h31, 8'h30, 8'h30, 8'h39, 8'h39, 8'h39};

        rst = 1'b0; power = 1'b0; car = vecs[0].car; time_cnt = vecs[0].tcnt;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_EN", EN, 0);   chk("rst_RS", RS, 0);   chk("rst_RW", RW, 0);
        chk("rst_data", data_bus, 0); chk("rst_busy", busy, 0); chk("rst_done", frame_done, 0);

        // Power-up: INIT then first frame.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); power = 1'b1;
        wait_frames(1, 400, "t1_frame_done");
        chk("t1_byte_count", cap_q.size(), 18);
        check_init(0, "t1_init");
        check_frame(4, vecs[0], "t1_frame");
        chk("t1_busy_idle", busy, 0);

        // Static inputs: no redraw.
        base = cap_q.size();
        repeat (500) @(negedge clk);
        chk("t2_idle_no_en", cap_q.size(), base);
        chk("t2_idle_frames", frames_done, 1);

        // Table: one redraw per input change, no INIT.
        for (int i = 1; i < 6; i++) begin
            base = cap_q.size();
            fd = frames_done;
            car = vecs[i].car;
            time_cnt = vecs[i].tcnt;
            wait_frames(fd + 1, 400, $sformatf("vec%0d_done", i));
            check_frame(base, vecs[i], $sformatf("vec%0d", i));
            repeat (40) @(negedge clk);
            chk($sformatf("vec%0d_single_frame", i), cap_q.size(), base + 14);
        end

        // Change zone 0 during byte 3: current frame unchanged, one follow-up frame.
        base = cap_q.size(); fd = frames_done;
        car = 8'h3C; time_cnt = 7'd8;
        wait_size(base + 3, 300, "t3_reach_byte3");
        car = 8'h35;
        wait_frames(fd + 2, 300, "t3_two_frames");
        v = '{8'h3C, 7'd8, 8'h31, 8'h32, 8'h30, 8'h33, 8'h30, 8'h38};
        check_frame(base, v, "t3_first");
        v = '{8'h35, 7'd8, 8'h30, 8'h35, 8'h30, 8'h33, 8'h30, 8'h38};
        check_frame(base + 14, v, "t3_second");
        repeat (40) @(negedge clk);
        chk("t3_no_third", cap_q.size(), base + 28);

        // Power drop during PULSE of frame byte 5.
        base = cap_q.size(); fd = frames_done;
        time_cnt = 7'd9;
        wait_size(base + 5, 300, "t5_reach_byte5");
        chk_width = 1'b0;
        power = 1'b0;
        @(posedge clk); #1;
        chk("t5_off_EN", EN, 0); chk("t5_off_busy", busy, 0);
        chk("t5_off_data", data_bus, 0); chk("t5_off_RS", RS, 0);
        repeat (10) @(negedge clk);
        chk("t5_no_done", frames_done, fd);
        chk_width = 1'b1;
        power = 1'b1;
        wait_frames(fd + 1, 400, "t5_reinit_frame");
        check_init(base + 5, "t5_init");
        v = '{8'h35, 7'd9, 8'h30, 8'h35, 8'h30, 8'h33, 8'h30, 8'h39};
        check_frame(base + 9, v, "t5_frame");

        // Asynchronous reset mid-frame.
        base = cap_q.size(); fd = frames_done;
        time_cnt = 7'd10;
        wait_size(base + 3, 300, "t6_reach_byte3");
        chk_width = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_EN", EN, 0); chk("t6_rst_RS", RS, 0); chk("t6_rst_data", data_bus, 0);
        chk("t6_rst_busy", busy, 0); chk("t6_rst_done", frame_done, 0);
        repeat (3) @(negedge clk);
        chk_width = 1'b1;
        rst = 1'b1;
        wait_frames(fd + 1, 400, "t6_reinit_frame");
        check_init(base + 3, "t6_init");
        v = '{8'h35, 7'd10, 8'h30, 8'h35, 8'h30, 8'h33, 8'h31, 8'h30};
        check_frame(base + 7, v, "t6_frame");
        repeat (100) @(negedge clk);
        chk("t6_single_frame", cap_q.size(), base + 21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_zone_display.md
Name: lcd_zone_display

Overview:
- Next-generation parking-lot LCD driver for an HD44780-compatible 8-bit character module (write-only).
- Shows free-space counts for ZONES parking zones on line 1 and the elapsed time on line 2.
- Replaces the separate scan clock with an internal tick divider on the single system clock.
- Takes a coherent snapshot of its inputs for each frame and redraws only when an input changes.

Parameters:
- ZONES, 2, number of zones shown; legal range 1..4.
- CAR_W, 4, width of each zone count; legal range 1..7.
- TIME_W, 6, width of time_cnt; legal range 1..7.
- TICK_DIV, 20, clk cycles per LCD step; must be at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- power  in  1  display enable; low blanks the bus and aborts activity.
- car  in  ZONES*CAR_W  packed zone counts; zone z occupies bits [z*CAR_W +: CAR_W].
- time_cnt  in  TIME_W  elapsed-time value.
- RW  out  1  always 0 (write-only).
- EN  out  1  LCD enable strobe.
- RS  out  1  0 = command byte, 1 = data byte.
- data_bus  out  8  LCD data.
- busy  out  1  high while INIT or FRAME is in progress.
- frame_done  out  1  one-cycle pulse after the last byte of each frame.

Behaviour:
- Reset (rst=0, asynchronous): RW=0, EN=0, RS=0, data_bus=0, busy=0, frame_done=0, state=OFF, tick counter=0, snapshot cleared, "dirty" flag set.
- Tick counter:
  - Counts 0..TICK_DIV-1 while power=1 and is held at 0 while power=0.
  - tick is asserted for one cycle when the count is TICK_DIV-1.
  - All byte-phase advances happen only on tick.
- Byte write takes 3 ticks:
  - SETUP: RS and data_bus driven, EN=0.
  - PULSE: EN=1.
  - HOLD: EN=0, RS and data unchanged.
  - The next byte's SETUP follows immediately.
- States: OFF, INIT, IDLE, FRAME.
  - OFF to INIT: on the first tick with power=1.
  - INIT sends commands 0x38, 0x0C, 0x06, 0x01, then enters IDLE with dirty=1.
  - IDLE to FRAME: on a tick when dirty=1. Latch car and time_cnt into the snapshot on that same cycle, then clear dirty.
  - FRAME sends 4*ZONES+6 bytes, then pulses frame_done and returns to IDLE.
- dirty is set whenever the live inputs differ from the snapshot, compared every clk, including during a FRAME.
  - A change mid-frame does not alter the frame in progress.
  - It forces exactly one further redraw after that frame completes.
- Frame byte order:
  1. Command 0x80.
  2. For each zone z=0..ZONES-1, data bytes 0x41+z, tens digit, units digit, 0x20.
  3. Command 0xC0.
  4. Data bytes 0x54, 0x3A, time tens digit, time units digit.
- Digits are ASCII 0x30+d.
  - tens = v/10 and units = v%10 for v ≤ 99.
  - v > 99 saturates to "99".
  - Conversion is combinational from the snapshot, never from the live inputs.
- Power dropping (power=0) in any state, next clk:
  - EN=0, data_bus=0, RS=0, busy=0, state=OFF.
  - The in-progress byte is abandoned.
  - A later power rise re-runs the full INIT.
- busy=1 exactly in INIT and FRAME.
- frame_done is asserted in the cycle IDLE is entered from FRAME.

Test Plan:
1. TICK_DIV=2, ZONES=2, rst low then high, power=1, car={4'd3,4'd12}, time_cnt=7.
   - Expect bytes 38,0C,06,01, then 80, 41,31,32,20, 42,30,33,20, C0, 54,3A,30,37.
   - RS=0 only on 38/0C/06/01/80/C0.
   - EN high exactly 2 clk per byte, 3 ticks per byte.
   - One frame_done pulse, then busy=0 and the bus holds idle.
2. After test 1 with inputs static for 500 clk: no EN pulse occurs.
   - Then set time_cnt=45: exactly one new frame (no INIT) whose last bytes are 34,35.
3. Change car zone 0 to 5 during byte 3 of a frame.
   - The current frame still shows 12.
   - A second frame follows immediately and shows 05.
4. time_cnt=63 with TIME_W=7 set to 120: line-2 digits are 36,33 and then 39,39.
5. Drop power during the PULSE of the 5th frame byte.
   - Next clk: EN=0, busy=0, data_bus=0.
   - On power re-rise: full INIT (38 first), then a complete frame.
6. Assert rst mid-frame.
   - All outputs are 0 asynchronously.
   - On release with power=1: INIT followed by one frame.
